pipelined_addsub: RTL and testbench

Parametrised, multi-lane, fixed-latency add/subtract pipeline with valid/ready flow control, per-lane overflow detection and optional saturation. It replaces the free-running fixed-latency adder in datapaths that need backpressure, SIMD lanes, or subtraction. It sits between an upstream producer and a downstream consumer, both using valid/ready. A sideband tag travels with each beat.

---
 rtl/pipe_arith_pkg.sv | 16 +
 rtl/addsub_lane.sv | 50 +++++
 rtl/pipelined_addsub.sv | 107 ++++++++++
 tb/tb_pipelined_addsub.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_arith_pkg.sv
// Shared definitions for the fixed-latency arithmetic pipes: op encoding and
// the per-lane result record.
package pipe_arith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest lane any arithmetic pipe is expected to carry in a lane result.
    localparam int LANE_MAX_W = 64;

    typedef struct packed {
        logic [LANE_MAX_W-1:0] sum;
        logic                  ovf;
    } lane_res_t;

endpackage

// File: rtl/addsub_lane.sv
// One lane of combinational add/subtract with overflow detection and
// optional clamping to the representable range.
module addsub_lane
    import pipe_arith_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit SIGNED   = 1'b0,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] raw;
    logic             ovf_w;

    // Clamp target: signed picks the rail on the side of the true result,
    // whose sign always equals a's sign when overflow occurs.
    function automatic logic [WIDTH-1:0] sat_value(input logic is_sub, input logic neg);
        logic [WIDTH-1:0] v;
        if (SIGNED) begin
            v = '1;
            v[WIDTH-1] = 1'b0;
            if (neg) v = ~v;
        end else begin
            v = is_sub ? '0 : '1;
        end
        return v;
    endfunction

    always_comb begin
        ext = (op == OP_SUB) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        raw = ext[WIDTH-1:0];
        if (SIGNED) begin
            if (op == OP_SUB)
                ovf_w = (a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
            else
                ovf_w = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        end else begin
            ovf_w = ext[WIDTH];
        end
        ovf = ovf_w;
        sum = (SATURATE && ovf_w) ? sat_value(op == OP_SUB, a[WIDTH-1]) : raw;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Multi-lane add/subtract pipeline with valid/ready flow control; stages
// collapse bubbles so any empty slot keeps the input ready.
module pipelined_addsub
    import pipe_arith_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LANES    = 1,
    parameter int LATENCY  = 4,
    parameter int TAG_W    = 8,
    parameter bit SIGNED   = 1'b0,
    parameter bit SATURATE = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_op,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_sum,
    output logic [LANES-1:0]       out_ovf,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int DW = LANES * WIDTH;

    logic [DW-1:0]    lane_sum;
    logic [LANES-1:0] lane_ovf;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        addsub_lane #(
            .WIDTH   (WIDTH),
            .SIGNED  (SIGNED),
            .SATURATE(SATURATE)
        ) u_lane (
            .a  (in_a[k*WIDTH +: WIDTH]),
            .b  (in_b[k*WIDTH +: WIDTH]),
            .op (in_op),
            .sum(lane_sum[k*WIDTH +: WIDTH]),
            .ovf(lane_ovf[k])
        );
    end

    logic             vld_q [LATENCY];
    logic             vld_d [LATENCY];
    logic [DW-1:0]    sum_q [LATENCY];
    logic [DW-1:0]    sum_d [LATENCY];
    logic [LANES-1:0] ovf_q [LATENCY];
    logic [LANES-1:0] ovf_d [LATENCY];
    logic [TAG_W-1:0] tag_q [LATENCY];
    logic [TAG_W-1:0] tag_d [LATENCY];
    logic [LATENCY-1:0] adv;

    always_comb begin
        adv = '0;
        adv[LATENCY-1] = !vld_q[LATENCY-1] || out_ready;
        for (int i = LATENCY - 2; i >= 0; i--) begin
            adv[i] = !vld_q[i] || adv[i+1];
        end
        // Stages come out of reset empty, so reset must gate ready explicitly.
        in_ready = adv[0] && reset;

        vld_d = vld_q;
        sum_d = sum_q;
        ovf_d = ovf_q;
        tag_d = tag_q;
        if (adv[0]) begin
            vld_d[0] = in_valid;
            sum_d[0] = lane_sum;
            ovf_d[0] = lane_ovf;
            tag_d[0] = in_tag;
        end
        for (int i = 1; i < LATENCY; i++) begin
            if (adv[i]) begin
                vld_d[i] = vld_q[i-1];
                sum_d[i] = sum_q[i-1];
                ovf_d[i] = ovf_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                sum_q[i] <= '0;
                ovf_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            sum_q <= sum_d;
            ovf_q <= ovf_d;
            tag_q <= tag_d;
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_sum   = sum_q[LATENCY-1];
    assign out_ovf   = ovf_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench: four configurations driven in lockstep through streaming,
// saturation, lanes, backpressure, bubble collapse and mid-flight reset.
module tb_pipelined_addsub;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       vld   = 1'b0;
    logic       op    = 1'b0;
    logic       ordy  = 1'b1;
    logic [7:0] tag   = 8'h00;
    logic [7:0] wa = 8'h00, wb = 8'h00, sa = 8'h00, sb = 8'h00, ua = 8'h00, ub = 8'h00;
    logic [31:0] la = 32'h0, lb = 32'h0;

    logic       rdy_w, rdy_s, rdy_u, rdy_l;
    logic       ov_w, ov_s, ov_u, ov_l;
    logic [7:0] sum_w, sum_s, sum_u;
    logic [31:0] sum_l;
    logic       of_w, of_s, of_u;
    logic [3:0] of_l;
    logic [7:0] tg_w, tg_s, tg_u, tg_l;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    pipelined_addsub #(.WIDTH(8), .LANES(1), .LATENCY(4), .TAG_W(8), .SIGNED(1'b0), .SATURATE(1'b0)) u_wrap (
        .clock(clock), .reset(reset), .in_valid(vld), .in_ready(rdy_w), .in_op(op),
        .in_a(wa), .in_b(wb), .in_tag(tag), .out_valid(ov_w), .out_ready(ordy),
        .out_sum(sum_w), .out_ovf(of_w), .out_tag(tg_w));

    pipelined_addsub #(.WIDTH(8), .LANES(1), .LATENCY(4), .TAG_W(8), .SIGNED(1'b1), .SATURATE(1'b1)) u_ssat (
        .clock(clock), .reset(reset), .in_valid(vld), .in_ready(rdy_s), .in_op(op),
        .in_a(sa), .in_b(sb), .in_tag(tag), .out_valid(ov_s), .out_ready(ordy),
        .out_sum(sum_s), .out_ovf(of_s), .out_tag(tg_s));

    pipelined_addsub #(.WIDTH(8), .LANES(1), .LATENCY(4), .TAG_W(8), .SIGNED(1'b0), .SATURATE(1'b1)) u_usat (
        .clock(clock), .reset(reset), .in_valid(vld), .in_ready(rdy_u), .in_op(op),
        .in_a(ua), .in_b(ub), .in_tag(tag), .out_valid(ov_u), .out_ready(ordy),
        .out_sum(sum_u), .out_ovf(of_u), .out_tag(tg_u));

    pipelined_addsub #(.WIDTH(8), .LANES(4), .LATENCY(4), .TAG_W(8), .SIGNED(1'b0), .SATURATE(1'b0)) u_lanes (
        .clock(clock), .reset(reset), .in_valid(vld), .in_ready(rdy_l), .in_op(op),
        .in_a(la), .in_b(lb), .in_tag(tag), .out_valid(ov_l), .out_ready(ordy),
        .out_sum(sum_l), .out_ovf(of_l), .out_tag(tg_l));

    typedef struct packed {
        logic       op;
        logic [7:0] tag;
        logic [7:0] wa, wb, ws;
        logic       wo;
        logic [7:0] sa, sb, ss;
        logic       so;
        logic [7:0] ua, ub, us;
        logic       uo;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic drive_vec(input int i);
        vld = 1'b1;
        op  = tbl[i].op;
        tag = tbl[i].tag;
        wa = tbl[i].wa; wb = tbl[i].wb;
        sa = tbl[i].sa; sb = tbl[i].sb;
        ua = tbl[i].ua; ub = tbl[i].ub;
        la = (i == 0) ? 32'h017F_FF10 : 32'h0;
        lb = (i == 0) ? 32'h0101_01F0 : 32'h0;
    endtask

    task automatic clear_side();
        op = 1'b0;
        sa = 8'h00; sb = 8'h00; ua = 8'h00; ub = 8'h00; la = 32'h0; lb = 32'h0;
    endtask

    initial begin
        int acc;
        int k;
        logic r;

        //            op    tag    wa     wb     ws     wo    sa     sb     ss     so    ua     ub     us     uo
        tbl[0] = '{1'b0, 8'h11, 8'd3,  8'd4,  8'd7,  1'b0, 8'd100, 8'd100, 8'h7F, 1'b1, 8'd200, 8'd100, 8'hFF, 1'b1};
        tbl[1] = '{1'b0, 8'h22, 8'd10, 8'd20, 8'd30, 1'b0, 8'd20,  8'd30,  8'd50, 1'b0, 8'd1,   8'd2,   8'd3,  1'b0};
        tbl[2] = '{1'b0, 8'h33, 8'hFF, 8'h01, 8'h00, 1'b1, 8'd0,   8'd0,   8'd0,  1'b0, 8'd0,   8'd0,   8'd0,  1'b0};
        tbl[3] = '{1'b1, 8'h44, 8'd9,  8'd4,  8'd5,  1'b0, 8'h9C,  8'd100, 8'h80, 1'b1, 8'd5,   8'd10,  8'h00, 1'b1};
        tbl[4] = '{1'b1, 8'h55, 8'd4,  8'd9,  8'hFB, 1'b1, 8'd50,  8'd20,  8'd30, 1'b0, 8'd10,  8'd5,   8'd5,  1'b0};

        // Reset state
        #1 reset = 1'b0;
        #2;
        chk("rst_in_ready", rdy_w, 1'b0);
        chk("rst_out_valid", ov_w, 1'b0);
        chk("rst_out_sum", sum_w, 8'h00);
        chk("rst_out_tag", tg_w, 8'h00);
        chk("rst_lane_ovf", of_l, 4'h0);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("rel_in_ready", rdy_w, 1'b1);

        // Streaming, saturation and lanes in one back-to-back burst
        drive_vec(0);
        for (int c = 0; c < 9; c++) begin
            @(posedge clock); #1;
            chk("stream_ready", rdy_w, 1'b1);
            chk("stream_valid", ov_w, (c >= 3 && c <= 7));
            if (c >= 3 && c <= 7) begin
                k = c - 3;
                chk("wrap_sum", sum_w, tbl[k].ws);
                chk("wrap_ovf", of_w, tbl[k].wo);
                chk("wrap_tag", tg_w, tbl[k].tag);
                chk("ssat_sum", sum_s, tbl[k].ss);
                chk("ssat_ovf", of_s, tbl[k].so);
                chk("usat_sum", sum_u, tbl[k].us);
                chk("usat_ovf", of_u, tbl[k].uo);
                chk("lane_sum", sum_l, (k == 0) ? 32'h0280_0000 : 32'h0);
                chk("lane_ovf", of_l, (k == 0) ? 4'b0011 : 4'b0000);
            end
            if (c + 1 < 5) drive_vec(c + 1);
            else vld = 1'b0;
        end
        clear_side();

        // Backpressure: fill the pipe with out_ready low
        ordy = 1'b0;
        acc = 0;
        vld = 1'b1; tag = 8'hA0; wa = 8'd0; wb = 8'd0;
        for (int j = 0; j < 7; j++) begin
            r = rdy_w;
            @(posedge clock); #1;
            if (r) begin
                acc++;
                tag = 8'(8'hA0 + acc); wa = 8'(acc); wb = 8'(acc);
            end
        end
        chk("bp_accepted", 64'(acc), 64'd4);
        chk("bp_ready_low", rdy_w, 1'b0);
        chk("bp_head_valid", ov_w, 1'b1);
        chk("bp_head_tag", tg_w, 8'hA0);
        vld = 1'b0;
        ordy = 1'b1;
        #1;
        chk("bp_ready_rise", rdy_w, 1'b1);
        for (int n = 1; n <= 4; n++) begin
            @(posedge clock); #1;
            chk("bp_drain_valid", ov_w, (n < 4));
            if (n < 4) begin
                chk("bp_drain_tag", tg_w, 8'(8'hA0 + n));
                chk("bp_drain_sum", sum_w, 8'(2 * n));
            end
        end

        // Bubble collapse: a lone beat stalls at the head, more pack behind
        ordy = 1'b0;
        vld = 1'b1; tag = 8'hB0; wa = 8'd5; wb = 8'd6;
        for (int j = 0; j < 10; j++) begin
            @(posedge clock); #1;
            chk("bubble_ready", rdy_w, 1'b1);
            if (j == 4) begin
                vld = 1'b1; tag = 8'hB1; wa = 8'd1; wb = 8'd1;
            end else if (j == 5) begin
                vld = 1'b1; tag = 8'hB2; wa = 8'd2; wb = 8'd2;
            end else begin
                vld = 1'b0;
            end
        end
        chk("bubble_head_valid", ov_w, 1'b1);
        chk("bubble_head_tag", tg_w, 8'hB0);
        chk("bubble_head_sum", sum_w, 8'd11);
        ordy = 1'b1;
        @(posedge clock); #1;
        chk("bubble_next_tag", tg_w, 8'hB1);
        chk("bubble_next_valid", ov_w, 1'b1);
        @(posedge clock); #1;
        chk("bubble_last_tag", tg_w, 8'hB2);
        chk("bubble_last_sum", sum_w, 8'd4);
        @(posedge clock); #1;
        chk("bubble_empty", ov_w, 1'b0);

        // Reset with three beats in flight
        for (int j = 0; j < 3; j++) begin
            vld = 1'b1; tag = 8'(8'hC0 + j); wa = 8'(j); wb = 8'd1;
            @(posedge clock); #1;
        end
        vld = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", rdy_w, 1'b0);
        chk("mid_rst_valid", ov_w, 1'b0);
        chk("mid_rst_sum", sum_w, 8'h00);
        chk("mid_rst_tag", tg_w, 8'h00);
        chk("mid_rst_ovf", of_w, 1'b0);
        @(posedge clock);
        @(posedge clock); #1;
        chk("mid_rst_hold", ov_w, 1'b0);
        reset = 1'b1;
        #1;
        chk("post_rst_ready", rdy_w, 1'b1);
        vld = 1'b1; tag = 8'hD0; wa = 8'd1; wb = 8'd1;
        for (int j = 0; j < 6; j++) begin
            @(posedge clock); #1;
            if (j == 0) vld = 1'b0;
            chk("post_rst_valid", ov_w, (j == 3));
            if (j == 3) begin
                chk("post_rst_tag", tg_w, 8'hD0);
                chk("post_rst_sum", sum_w, 8'd2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
